// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane decode helper
// used by the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_t;

  // Little-endian byte enables for a transfer of the given size at addr[1:0].
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array: byte-enabled synchronous write, asynchronous read
// of the same word index. Contents are intentionally never reset.
module ahb_sram_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Commit each enabled byte lane at the clock edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: captures the address phase, checks legality, inserts
// configurable wait states, answers illegal accesses with a two-cycle ERROR
// and performs byte-enabled writes at the edge that ends the data phase.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int               ADDRW       = 32,
  parameter int               DATAW       = 32,
  parameter int               MEM_DEPTH   = 256,
  parameter logic [ADDRW-1:0] BASE_ADDR   = {ADDRW{1'b0}},
  parameter int               WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [ADDRW-1:0] HADDR,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  logic [1:0]       HTRANS,
  input  logic [DATAW-1:0] HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [DATAW-1:0] HRDATA,
  output logic             HRESP
);

  localparam int               IDXW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRW-1:0] SPAN    = ADDRW'(4 * MEM_DEPTH);
  localparam logic [3:0]       WS_INIT = 4'(WAIT_STATES);

  slv_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [1:0]       lo_q, lo_d;
  logic [2:0]       size_q, size_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  htrans_t          trans_s;
  logic             capture_s;
  logic             legal_s;
  logic             aligned_s;
  logic [ADDRW-1:0] offset_s;
  logic             we_s;
  logic [3:0]       be_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign trans_s   = htrans_t'(HTRANS);
  assign capture_s = HSEL && HREADY &&
                     ((trans_s == HTRANS_NONSEQ) || (trans_s == HTRANS_SEQ));
  assign offset_s  = HADDR - BASE_ADDR;
  assign unused_s  = ^{HBURST, HPROT};

  // Legality of the address phase currently on the bus
  always_comb begin
    aligned_s = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: aligned_s = 1'b1;
      HSIZE_HALF: aligned_s = (HADDR[0] == 1'b0);
      HSIZE_WORD: aligned_s = (HADDR[1:0] == 2'b00);
      default:    aligned_s = 1'b0;
    endcase
    legal_s = (HADDR >= BASE_ADDR) && (offset_s < SPAN) && aligned_s;
  end

  // State register and captured address-phase information
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= {IDXW{1'b0}};
      lo_q        <= 2'b00;
      size_q      <= 3'b000;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Next-state logic; captures only at edges that complete our data phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (capture_s) begin
          write_d = HWRITE;
          idx_d   = offset_s[IDXW+1:2];
          lo_d    = HADDR[1:0];
          size_d  = HSIZE;
          if (!legal_s) begin
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = ST_DATA;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Bus response for the upcoming cycle, registered with the state
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    case (state_d)
      ST_WAIT: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      ST_IDLE, ST_DATA: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
    endcase
  end

  assign we_s = (state_q == ST_DATA) && write_q;
  assign be_s = byte_lanes(size_q, lo_q);

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDXW)
  ) u_mem (
    .clk   (HCLK),
    .we    (we_s),
    .be    (be_s),
    .addr  (idx_q),
    .wdata (HWDATA),
    .rdata (rdata_s)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slave instances (0 and 2 wait states) sharing one
// bus driver; a vector table is replayed on each, plus hand-written sequences
// for pipelining, wait-state hold, HREADY stall, IDLE/BUSY and reset abort.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel_drv;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        stall;
  int          sel;

  logic        hsel0, hsel2, hready0, hready2, hro0, hro2, hresp0, hresp2;
  logic [31:0] hrd0, hrd2;
  logic        hro, hresp;
  logic [31:0] hrd;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[18];
  exp_t sb[$];

  always #5 clk = ~clk;

  assign hsel0   = hsel_drv && (sel == 0);
  assign hsel2   = hsel_drv && (sel == 2);
  assign hready0 = hro0 & ~stall;
  assign hready2 = hro2 & ~stall;
  assign hro     = (sel == 2) ? hro2   : hro0;
  assign hresp   = (sel == 2) ? hresp2 : hresp0;
  assign hrd     = (sel == 2) ? hrd2   : hrd0;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HWDATA(hwdata), .HREADY(hready0), .HREADYOUT(hro0), .HRDATA(hrd0), .HRESP(hresp0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HWDATA(hwdata), .HREADY(hready2), .HREADYOUT(hro2), .HRDATA(hrd2), .HRESP(hresp2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // One non-pipelined transfer; entered and left just after a negedge.
  task automatic do_xfer(input vec_t v, input int ws, input string tag);
    exp_t e;
    int   waits;
    hsel_drv = 1'b1; htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.wr; hsize = v.size;
    e.err   = v.err;
    e.rdata = (v.wr || v.err) ? 32'h0000_0000 : v.rdata;
    e.waits = v.err ? 1 : ws;
    sb.push_back(e);
    @(negedge clk);
    hsel_drv = 1'b0; htrans = HTRANS_IDLE; hwdata = v.wdata;
    waits = 0;
    while (hro !== 1'b1 && waits < 40) begin
      check({tag, "_wresp"}, {31'd0, hresp}, {31'd0, v.err});
      check({tag, "_wdata"}, hrd, 32'h0000_0000);
      waits++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, "_waits"}, waits, e.waits);
    check({tag, "_resp"}, {31'd0, hresp}, {31'd0, e.err});
    check({tag, "_rdata"}, hrd, e.rdata);
  endtask

  initial begin
    rst_n = 1'b0; hsel_drv = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD;
    htrans = HTRANS_IDLE; hwdata = 32'h0; stall = 1'b0; sel = 0;

    vecs[0]  = mkv(1'b1, HSIZE_WORD, 32'h010, 32'hDEAD_BEEF, 32'h0,         1'b0);
    vecs[1]  = mkv(1'b0, HSIZE_WORD, 32'h010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mkv(1'b1, HSIZE_BYTE, 32'h013, 32'hAA00_0000, 32'h0,         1'b0);
    vecs[3]  = mkv(1'b1, HSIZE_HALF, 32'h010, 32'h0000_1234, 32'h0,         1'b0);
    vecs[4]  = mkv(1'b0, HSIZE_WORD, 32'h010, 32'h0,         32'hAAAD_1234, 1'b0);
    vecs[5]  = mkv(1'b1, HSIZE_WORD, 32'h400, 32'hFFFF_FFFF, 32'h0,         1'b1);
    vecs[6]  = mkv(1'b1, HSIZE_HALF, 32'h011, 32'hFFFF_FFFF, 32'h0,         1'b1);
    vecs[7]  = mkv(1'b0, HSIZE_WORD, 32'h010, 32'h0,         32'hAAAD_1234, 1'b0);
    vecs[8]  = mkv(1'b0, 3'b011,     32'h010, 32'h0,         32'h0,         1'b1);
    vecs[9]  = mkv(1'b1, HSIZE_WORD, 32'h3FC, 32'h0102_0304, 32'h0,         1'b0);
    vecs[10] = mkv(1'b1, HSIZE_BYTE, 32'h3FF, 32'h5500_0000, 32'h0,         1'b0);
    vecs[11] = mkv(1'b0, HSIZE_WORD, 32'h3FC, 32'h0,         32'h5502_0304, 1'b0);
    vecs[12] = mkv(1'b0, HSIZE_WORD, 32'h400, 32'h0,         32'h0,         1'b1);
    vecs[13] = mkv(1'b1, HSIZE_WORD, 32'h011, 32'hFFFF_FFFF, 32'h0,         1'b1);
    vecs[14] = mkv(1'b1, HSIZE_HALF, 32'h012, 32'hBEEF_0000, 32'h0,         1'b0);
    vecs[15] = mkv(1'b0, HSIZE_WORD, 32'h010, 32'h0,         32'hBEEF_1234, 1'b0);
    vecs[16] = mkv(1'b1, HSIZE_BYTE, 32'h3FD, 32'h0000_AB00, 32'h0,         1'b0);
    vecs[17] = mkv(1'b0, HSIZE_WORD, 32'h3FC, 32'h0,         32'h5502_AB04, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_hro0", {31'd0, hro0}, 32'd1);
    check("rst_hresp0", {31'd0, hresp0}, 32'd0);
    check("rst_hrd0", hrd0, 32'h0);
    check("rst_hro2", {31'd0, hro2}, 32'd1);
    check("rst_hrd2", hrd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // vector table on both wait-state configurations
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0) ? 0 : 2;
      for (int i = 0; i < 18; i++) begin
        do_xfer(vecs[i], sel, $sformatf("v%0d_ws%0d", i, sel));
      end
    end

    // back-to-back write then read of the same word, zero wait
    sel = 0;
    hsel_drv = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h020; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    check("pipe_wr_ready", {31'd0, hro}, 32'd1);
    hwdata = 32'h1122_3344; hwrite = 1'b0;
    @(negedge clk);
    check("pipe_rd_ready", {31'd0, hro}, 32'd1);
    check("pipe_rd_data", hrd, 32'h1122_3344);
    hsel_drv = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("pipe_idle_ready", {31'd0, hro}, 32'd1);
    check("pipe_idle_data", hrd, 32'h0);

    // two wait states with the next address held during the waits
    sel = 2;
    do_xfer(mkv(1'b1, HSIZE_WORD, 32'h030, 32'hCAFE_F00D, 32'h0, 1'b0), 2, "ws_prep");
    @(negedge clk);
    hsel_drv = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h030; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(negedge clk);
    check("ws_w1_ready", {31'd0, hro}, 32'd0);
    haddr = 32'h3FC;
    @(negedge clk);
    check("ws_w2_ready", {31'd0, hro}, 32'd0);
    check("ws_w2_data", hrd, 32'h0);
    @(negedge clk);
    check("ws_done_ready", {31'd0, hro}, 32'd1);
    check("ws_done_data", hrd, 32'hCAFE_F00D);
    @(negedge clk);
    check("ws_next_w1", {31'd0, hro}, 32'd0);
    hsel_drv = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("ws_next_w2", {31'd0, hro}, 32'd0);
    @(negedge clk);
    check("ws_next_ready", {31'd0, hro}, 32'd1);
    check("ws_next_data", hrd, 32'h5502_AB04);
    @(negedge clk);

    // HREADY low from another slave: no capture; IDLE/BUSY give zero-wait OKAY
    sel = 0;
    do_xfer(mkv(1'b1, HSIZE_WORD, 32'h040, 32'h0BAD_F00D, 32'h0, 1'b0), 0, "stall_prep");
    @(negedge clk);
    stall = 1'b1; hsel_drv = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h040; hwrite = 1'b1;
    @(negedge clk);
    check("stall_ready", {31'd0, hro}, 32'd1);
    check("stall_resp", {31'd0, hresp}, 32'd0);
    stall = 1'b0; hwdata = 32'hFFFF_FFFF; htrans = HTRANS_BUSY; haddr = 32'h400;
    @(negedge clk);
    check("busy_ready", {31'd0, hro}, 32'd1);
    check("busy_resp", {31'd0, hresp}, 32'd0);
    htrans = HTRANS_IDLE; hsize = 3'b111; haddr = 32'h401;
    @(negedge clk);
    check("idle_ready", {31'd0, hro}, 32'd1);
    check("idle_resp", {31'd0, hresp}, 32'd0);
    hsel_drv = 1'b0; hsize = HSIZE_WORD;
    do_xfer(mkv(1'b0, HSIZE_WORD, 32'h040, 32'h0, 32'h0BAD_F00D, 1'b0), 0, "stall_rd");
    @(negedge clk);

    // reset during a wait cycle aborts the write
    sel = 2;
    do_xfer(mkv(1'b1, HSIZE_WORD, 32'h020, 32'h5A5A_5A5A, 32'h0, 1'b0), 2, "rst_prep");
    @(negedge clk);
    hsel_drv = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h020; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    check("rstw_wait", {31'd0, hro}, 32'd0);
    hsel_drv = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    #1;
    check("rstw_ready", {31'd0, hro2}, 32'd1);
    check("rstw_resp", {31'd0, hresp2}, 32'd0);
    check("rstw_data", hrd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_xfer(mkv(1'b0, HSIZE_WORD, 32'h020, 32'h0, 32'h5A5A_5A5A, 1'b0), 2, "rstw_rd");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
